dmem_bridge: RTL

//  Memory-stage bridge between the pipeline's M-stage data access (wen/addr/wdata)
//  and a variable-latency data SRAM with req/addr_ok/data_ok handshake.

---
 rtl/dmem_bridge.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dmem_bridge.sv
// Memory-stage bridge: turns the M-stage load/store into an SRAM req/addr_ok/data_ok
// transaction and stalls the pipeline until it completes. Option: DMEM_BRIDGE_WBUF_EN (posted stores).
module dmem_bridge #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_en,
    input  logic [3:0]       cpu_wen,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    output logic [DW-1:0]    cpu_rdata,
    output logic             cpu_stall,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [1:0]       mem_size,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic             mem_addr_ok,
    input  logic             mem_data_ok,
    input  logic [DW-1:0]    mem_rdata,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic       start;
    logic       wr_block;
    logic       posted;
    logic       rd_capture;
    logic [1:0] size_dec;

`ifdef DMEM_BRIDGE_WBUF_EN
    logic wr_pending;

    // A posted store is outstanding from its addr_ok until its data_ok.
    always_ff @(posedge clk) begin
        if (rst)
            wr_pending <= 1'b0;
        else if (state == S_REQ && mem_addr_ok && mem_wr && !mem_data_ok)
            wr_pending <= 1'b1;
        else if (mem_data_ok)
            wr_pending <= 1'b0;
    end

    assign wr_block = wr_pending;
    assign posted   = mem_wr;
`else
    assign wr_block = 1'b0;
    assign posted   = 1'b0;
`endif

    assign start = (state == S_IDLE) && cpu_en && !wr_block;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_REQ;
            S_REQ: begin
                if (mem_addr_ok) begin
                    if (mem_data_ok || posted)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (mem_data_ok) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = (state == S_REQ);
        cpu_stall = !rst && cpu_en && (state != S_DONE);
    end

    always_comb begin
        case (cpu_wen)
            4'b1111:                            size_dec = 2'd2;
            4'b0011, 4'b1100:                   size_dec = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_dec = 2'd0;
            default:                            size_dec = 2'd2;
        endcase
    end

    // Request fields are latched once at IDLE->REQ and stay put until the next access.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr    <= 1'b0;
            mem_size  <= 2'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            mem_wr    <= (cpu_wen != 4'b0000);
            mem_size  <= (cpu_wen == 4'b0000) ? 2'd2 : size_dec;
            mem_addr  <= (cpu_wen == 4'b0000) ? {cpu_addr[AW-1:2], 2'b00} : cpu_addr;
            mem_wdata <= cpu_wdata;
        end
    end

    assign rd_capture = !mem_wr && mem_data_ok &&
                        ((state == S_WAIT) || (state == S_REQ && mem_addr_ok));

    always_ff @(posedge clk) begin
        if (rst)
            cpu_rdata <= '0;
        else if (rd_capture)
            cpu_rdata <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (cpu_stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule
